// File: rtl/ibex_alert_responder.sv
// ibex_alert_responder: receives the core/lockstep alert levels, raises an
// acknowledge-required interrupt per minor alert event, and locks the core down
// (fetch disabled, sticky until reset) on a major alert, an unacknowledged
// minor alert, or too many minor alerts.
//
// Optional feature: define IBEX_ALERT_MINOR_DECAY_EN to let the minor event
// counter decay by one every DecayPeriod cycles while not escalated.
module ibex_alert_responder #(
  parameter int MinorThreshold = 4,
  parameter int CntWidth       = 4,
  parameter int AckTimeout     = 64,
  parameter int DecayPeriod    = 1024
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                alert_minor_i,
  input  logic                alert_major_i,
  input  logic                alert_ack_i,
  output logic                irq_alert_o,
  output logic                esc_o,
  output logic                fetch_enable_o,
  output logic [CntWidth-1:0] minor_cnt_o
);

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StPending   = 2'd1,
    StEscalated = 2'd2
  } state_e;

  localparam int                 TmrW    = $clog2(AckTimeout);
  localparam logic [TmrW-1:0]    TmrLast = TmrW'(AckTimeout - 1);
  localparam logic [TmrW-1:0]    TmrOne  = TmrW'(1);
  localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
  localparam logic [CntWidth-1:0] CntThr = CntWidth'(MinorThreshold);

  logic                minor_q, minor_prev_q, major_q;
  logic                minor_ev, major_ev, esc_req;
  logic                cnt_inc, cnt_dec;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [TmrW-1:0]     tmr_q;
  state_e              state_q;
  logic                irq_q, esc_q;

  // Register the alert levels once and keep the previous minor sample for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      minor_q      <= 1'b0;
      minor_prev_q <= 1'b0;
      major_q      <= 1'b0;
    end else begin
      minor_q      <= alert_minor_i;
      minor_prev_q <= minor_q;
      major_q      <= alert_major_i;
    end
  end

  // A held minor level is one event; major is level-sensitive.
  assign minor_ev = minor_q & ~minor_prev_q;
  assign major_ev = major_q;

`ifdef IBEX_ALERT_MINOR_DECAY_EN
  localparam int DecayW = $clog2(DecayPeriod);
  logic [DecayW-1:0] decay_q;

  // Free-running decay timer; a wrap requests one decrement of the counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      decay_q <= '0;
    end else begin
      decay_q <= decay_q + DecayW'(1);
    end
  end

  assign cnt_dec = (&decay_q) && (state_q != StEscalated) && (cnt_q != '0);
`else
  logic unused_decay_period;
  assign unused_decay_period = (DecayPeriod > 0);
  assign cnt_dec = 1'b0;
`endif

  assign cnt_inc = minor_ev && (cnt_q != CntMax);

  // Next counter value: saturating increment, optional decrement, both cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_inc && !cnt_dec) begin
      cnt_d = cnt_q + CntOne;
    end else if (cnt_dec && !cnt_inc) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  // Threshold is judged on the count including this cycle's event.
  assign esc_req = major_ev || (cnt_d >= CntThr);

  // Minor event counter; keeps counting even after escalation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Alert FSM with ack timer; irq/esc are registered alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      irq_q   <= 1'b0;
      esc_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (esc_req) begin
            state_q <= StEscalated;
            esc_q   <= 1'b1;
          end else if (minor_ev) begin
            state_q <= StPending;
            tmr_q   <= '0;
            irq_q   <= 1'b1;
          end
        end
        StPending: begin
          if (esc_req) begin
            state_q <= StEscalated;
            irq_q   <= 1'b0;
            esc_q   <= 1'b1;
          end else if (minor_ev) begin
            // A fresh event restarts the ack window even if ack arrives now.
            tmr_q <= '0;
          end else if (alert_ack_i) begin
            state_q <= StIdle;
            irq_q   <= 1'b0;
          end else if (tmr_q == TmrLast) begin
            state_q <= StEscalated;
            irq_q   <= 1'b0;
            esc_q   <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TmrOne;
          end
        end
        StEscalated: begin
          state_q <= StEscalated;
        end
        default: begin
          // Unreachable encoding: fail safe into lockdown.
          state_q <= StEscalated;
          irq_q   <= 1'b0;
          esc_q   <= 1'b1;
        end
      endcase
    end
  end

  assign irq_alert_o    = irq_q;
  assign esc_o          = esc_q;
  assign fetch_enable_o = ~esc_q;
  assign minor_cnt_o    = cnt_q;

endmodule

// File: tb/tb_ibex_alert_responder.sv
// Testbench for ibex_alert_responder: a cycle model predicts every output each
// clock and queues it; the queue is drained and compared on the falling edge.
// Directed scenarios add explicit latency, timeout, threshold and race checks.
module tb_ibex_alert_responder;

  localparam int Thr  = 4;
  localparam int CW   = 4;
  localparam int AT   = 64;
  localparam int DP   = 16;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          a_min = 1'b0;
  logic          a_maj = 1'b0;
  logic          ack = 1'b0;
  logic          irq, esc, fe;
  logic [CW-1:0] cnt;

  int n_chk = 0;
  int n_pass = 0;

  ibex_alert_responder #(
    .MinorThreshold(Thr),
    .CntWidth      (CW),
    .AckTimeout    (AT),
    .DecayPeriod   (DP)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .alert_minor_i (a_min),
    .alert_major_i (a_maj),
    .alert_ack_i   (ack),
    .irq_alert_o   (irq),
    .esc_o         (esc),
    .fetch_enable_o(fe),
    .minor_cnt_o   (cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic          irq;
    logic          esc;
    logic          fe;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;
  exp_t sb_e;
  int   m_st, m_tmr, m_cnt, m_dec, m_nxt;
  bit   m_min, m_maj, m_prev;
  bit   ev_min, ev_maj, m_inc, m_dc, m_wrap;

  // Model state: 0 idle, 1 pending, 2 escalated.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_tmr = 0; m_cnt = 0; m_dec = 0;
      m_min = 0; m_maj = 0; m_prev = 0;
      sb_q.delete();
    end else begin
      ev_min = m_min && !m_prev;
      ev_maj = m_maj;
      m_wrap = 0;
`ifdef IBEX_ALERT_MINOR_DECAY_EN
      m_wrap = (m_dec == DP - 1);
`endif
      m_dec = (m_dec + 1) % DP;
      m_inc = ev_min && (m_cnt < CMAX);
      m_dc  = m_wrap && (m_st != 2) && (m_cnt > 0);
      m_nxt = m_cnt + int'(m_inc) - int'(m_dc);
      if (m_st != 2) begin
        if (ev_maj || m_nxt >= Thr) m_st = 2;
        else if (m_st == 0) begin
          if (ev_min) begin m_st = 1; m_tmr = 0; end
        end
        else if (ev_min) m_tmr = 0;
        else if (ack) m_st = 0;
        else if (m_tmr == AT - 1) m_st = 2;
        else m_tmr = m_tmr + 1;
      end
      m_cnt  = m_nxt;
      m_prev = m_min;
      m_min  = a_min;
      m_maj  = a_maj;
      m_e.irq = (m_st == 1);
      m_e.esc = (m_st == 2);
      m_e.fe  = (m_st != 2);
      m_e.cnt = CW'(m_cnt);
      sb_q.push_back(m_e);
    end
  end

  always @(negedge clk) begin
    if (rst_n && sb_q.size() > 0) begin
      sb_e = sb_q.pop_front();
      check_eq("sb_irq", int'(irq), int'(sb_e.irq));
      check_eq("sb_esc", int'(esc), int'(sb_e.esc));
      check_eq("sb_fe",  int'(fe),  int'(sb_e.fe));
      check_eq("sb_cnt", int'(cnt), int'(sb_e.cnt));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq({tag, "_irq"}, int'(irq), 0);
    check_eq({tag, "_esc"}, int'(esc), 0);
    check_eq({tag, "_fe"},  int'(fe),  1);
    check_eq({tag, "_cnt"}, int'(cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic pulse_minor();
    a_min = 1'b1;
    step();
    a_min = 1'b0;
    step();
  endtask

  task automatic ack_once();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic steps_until_esc(input int bound, output int n);
    n = 0;
    while (!esc && n < bound) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  int hi;
  int n;

  initial begin
    // Initial reset
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_irq", int'(irq), 0);
    check_eq("rst_esc", int'(esc), 0);
    check_eq("rst_fe",  int'(fe),  1);
    check_eq("rst_cnt", int'(cnt), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single minor held 3 cycles, ack 5 cycles after IRQ
    a_min = 1'b1;
    step();
    check_eq("t1_lat_early", int'(irq), 0);
    step();
    check_eq("t1_irq_rise", int'(irq), 1);
    hi = 1;
    step();
    a_min = 1'b0;
    hi += int'(irq);
    repeat (3) begin
      step();
      hi += int'(irq);
    end
    ack_once();
    hi += int'(irq);
    check_eq("t1_irq_cycles", hi, 5);
    check_eq("t1_idle_irq", int'(irq), 0);
    check_eq("t1_esc", int'(esc), 0);
    check_eq("t1_cnt", int'(cnt), 1);
    repeat (4) step();
    check_eq("t1_esc_later", int'(esc), 0);

    // Ack timeout, then ack/alerts ignored
    pulse_minor();
    check_eq("t2_irq", int'(irq), 1);
    steps_until_esc(200, n);
    check_eq("t2_timeout_cycles", n, AT);
    check_eq("t2_fe", int'(fe), 0);
    check_eq("t2_irq_off", int'(irq), 0);
    ack_once();
    pulse_minor();
    step();
    check_eq("t2_sticky_esc", int'(esc), 1);
    check_eq("t2_sticky_irq", int'(irq), 0);
    check_eq("t2_cnt_counts", int'(cnt), 3);
    apply_reset("t2_rst");

    // Major from idle
    a_maj = 1'b1;
    step();
    a_maj = 1'b0;
    check_eq("t3_esc_early", int'(esc), 0);
    step();
    check_eq("t3_esc", int'(esc), 1);
    check_eq("t3_fe", int'(fe), 0);
    check_eq("t3_cnt", int'(cnt), 0);
    repeat (5) step();
    check_eq("t3_esc_hold", int'(esc), 1);
    apply_reset("t3_rst");

    // Reset while pending
    pulse_minor();
    check_eq("t3b_irq", int'(irq), 1);
    repeat (5) step();
    apply_reset("t3b_rst");

    // Simultaneous major and minor
    a_min = 1'b1;
    a_maj = 1'b1;
    step();
    a_min = 1'b0;
    a_maj = 1'b0;
    step();
    check_eq("t3c_esc", int'(esc), 1);
    check_eq("t3c_cnt", int'(cnt), 1);
    apply_reset("t3c_rst");

    // Threshold: fourth minor escalates directly
    repeat (3) begin
      pulse_minor();
      check_eq("t4_irq", int'(irq), 1);
      ack_once();
      check_eq("t4_acked", int'(irq), 0);
    end
    pulse_minor();
    check_eq("t4_esc", int'(esc), 1);
    check_eq("t4_irq_skip", int'(irq), 0);
    check_eq("t4_cnt", int'(cnt), 4);
    apply_reset("t4_rst");

    // Race: ack and new minor edge together -> stay pending, timer restarts
    pulse_minor();
    repeat (10) step();
    a_min = 1'b1;
    step();
    a_min = 1'b0;
    ack_once();
    check_eq("t5a_stay_pending", int'(irq), 1);
    check_eq("t5a_cnt", int'(cnt), 2);
    steps_until_esc(200, n);
    check_eq("t5a_timer_restart", n, AT);
    apply_reset("t5a_rst");

    // Race: ack on the timeout cycle -> idle
    pulse_minor();
    repeat (AT - 1) step();
    ack_once();
    check_eq("t5b_esc", int'(esc), 0);
    check_eq("t5b_irq", int'(irq), 0);
    repeat (3) step();
    check_eq("t5b_esc_later", int'(esc), 0);
    apply_reset("t5b_rst");

    // Decay
    pulse_minor();
    ack_once();
    pulse_minor();
    ack_once();
    check_eq("t6_cnt2", int'(cnt), 2);
    repeat (32) step();
`ifdef IBEX_ALERT_MINOR_DECAY_EN
    check_eq("t6_decayed", int'(cnt), 0);
`else
    check_eq("t6_no_decay", int'(cnt), 2);
`endif

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
